// File: rtl/spi_baud_gen_param.sv
// SPI serial-clock generator: shadowed SPR/SPPR divisor, SCLK plus launch/sample strobes for the shifter.
// Optional frame edge counter and frame_done_o enabled by defining SPI_BRG_FRAME_CNT_EN.
module spi_baud_gen_param #(
  parameter int SPR_W      = 3,
  parameter int SPPR_W     = 3,
  parameter int FRAME_BITS = 8,
  localparam int DIV_W     = SPPR_W + (1 << SPR_W) + 1
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              cpol_i,
  input  logic              cphase_i,
  input  logic              spiswai_i,
  input  logic [1:0]        spi_mode_i,
  input  logic [SPR_W-1:0]  spr_i,
  input  logic [SPPR_W-1:0] sppr_i,
  input  logic              ss_i,
  output logic              sclk_o,
  output logic [DIV_W-1:0]  BaudRateDivisor_o,
  output logic              miso_receive_sclk_o,
  output logic              miso_receive_sclk0_o,
  output logic              mosi_send_sclk_o,
  output logic              mosi_send_sclk0_o
`ifdef SPI_BRG_FRAME_CNT_EN
  ,
  output logic              frame_done_o
`endif
);

  logic              enable_s;
  logic              frame_hold_s;
  logic [SPR_W-1:0]  spr_sh_r;
  logic [SPPR_W-1:0] sppr_sh_r;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  div_next_s;
  logic [DIV_W-1:0]  cnt_r;
  logic [DIV_W-1:0]  half_s;
  logic              last_s;
  logic              pre_s;
  logic              sample_s;
  logic              sclk_r;
  logic              rcv_r;
  logic              rcv0_r;
  logic              snd_r;
  logic              snd0_r;

  // Run qualification, half period and edge-type decode
  always_comb begin
    enable_s   = 1'b0;
    div_next_s = ((DIV_W'(sppr_sh_r) + DIV_W'(1)) << spr_sh_r) << 1;
    half_s     = div_r >> 1;
    pre_s      = 1'b0;
    if (!ss_i && ((spi_mode_i == 2'b00) || ((spi_mode_i == 2'b01) && !spiswai_i))) begin
      enable_s = 1'b1;
    end else begin
      enable_s = 1'b0;
    end
    if (half_s == DIV_W'(0)) begin
      half_s = DIV_W'(1);
    end else begin
      half_s = div_r >> 1;
    end
    last_s = (cnt_r == (half_s - DIV_W'(1)));
    // With a one-cycle half period the early strobe has no earlier slot, so it rides with the edge.
    if (half_s == DIV_W'(1)) begin
      pre_s = last_s;
    end else begin
      pre_s = (cnt_r == (half_s - DIV_W'(2)));
    end
    // A toggle away from cpol is the leading edge; cphase selects which edge samples.
    sample_s = (sclk_r == cpol_i) ^ cphase_i;
  end

`ifdef SPI_BRG_FRAME_CNT_EN
  localparam int EDGE_W = $clog2(2 * FRAME_BITS + 1);
  logic [EDGE_W-1:0] edge_cnt_r;
  logic              frame_done_r;

  // Frame-complete decode from the edge counter
  always_comb begin
    if (edge_cnt_r == EDGE_W'(2 * FRAME_BITS)) begin
      frame_hold_s = 1'b1;
    end else begin
      frame_hold_s = 1'b0;
    end
  end

  // SCLK edge counter and end-of-frame pulse
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      edge_cnt_r   <= EDGE_W'(0);
      frame_done_r <= 1'b0;
    end else if (!enable_s) begin
      edge_cnt_r   <= EDGE_W'(0);
      frame_done_r <= 1'b0;
    end else if (!frame_hold_s && last_s) begin
      edge_cnt_r   <= edge_cnt_r + EDGE_W'(1);
      frame_done_r <= (edge_cnt_r == EDGE_W'(2 * FRAME_BITS - 1));
    end else begin
      frame_done_r <= 1'b0;
    end
  end

  assign frame_done_o = frame_done_r;
`else
  assign frame_hold_s = 1'b0;
`endif

  // Divisor shadows track the register block only between frames
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      spr_sh_r  <= SPR_W'(0);
      sppr_sh_r <= SPPR_W'(0);
    end else if (!enable_s) begin
      spr_sh_r  <= spr_i;
      sppr_sh_r <= sppr_i;
    end else begin
      spr_sh_r  <= spr_sh_r;
      sppr_sh_r <= sppr_sh_r;
    end
  end

  // Registered active divisor
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      div_r <= DIV_W'(2);
    end else begin
      div_r <= div_next_s;
    end
  end

  // Half-period counter, SCLK and strobes
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      cnt_r  <= DIV_W'(0);
      sclk_r <= 1'b0;
      rcv_r  <= 1'b0;
      rcv0_r <= 1'b0;
      snd_r  <= 1'b0;
      snd0_r <= 1'b0;
    end else if (!enable_s || frame_hold_s) begin
      cnt_r  <= DIV_W'(0);
      sclk_r <= cpol_i;
      rcv_r  <= 1'b0;
      rcv0_r <= 1'b0;
      snd_r  <= 1'b0;
      snd0_r <= 1'b0;
    end else begin
      if (last_s) begin
        cnt_r  <= DIV_W'(0);
        sclk_r <= ~sclk_r;
      end else begin
        cnt_r  <= cnt_r + DIV_W'(1);
        sclk_r <= sclk_r;
      end
      rcv_r  <= last_s & sample_s;
      snd_r  <= last_s & ~sample_s;
      rcv0_r <= pre_s & sample_s;
      snd0_r <= pre_s & ~sample_s;
    end
  end

  assign sclk_o               = sclk_r;
  assign BaudRateDivisor_o    = div_r;
  assign miso_receive_sclk_o  = rcv_r;
  assign miso_receive_sclk0_o = rcv0_r;
  assign mosi_send_sclk_o     = snd_r;
  assign mosi_send_sclk0_o    = snd0_r;

endmodule

// File: tb/tb_spi_baud_gen_param.sv
// Self-checking bench for spi_baud_gen_param: directed scenarios plus randomized frames
// compared every cycle against an arithmetic reference model of the SCLK timeline.
module tb_spi_baud_gen_param;

  localparam int DIV_W = 12;

  logic             PCLK = 1'b0;
  logic             PRESET_n = 1'b0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic             spiswai = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [2:0]       spr = 3'd0;
  logic [2:0]       sppr = 3'd0;
  logic             ss = 1'b1;
  logic             sclk;
  logic [DIV_W-1:0] div;
  logic             rcv, rcv0, snd, snd0;
`ifdef SPI_BRG_FRAME_CNT_EN
  logic             frame_done;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  spi_baud_gen_param dut (
    .PCLK                 (PCLK),
    .PRESET_n             (PRESET_n),
    .cpol_i               (cpol),
    .cphase_i             (cpha),
    .spiswai_i            (spiswai),
    .spi_mode_i           (mode),
    .spr_i                (spr),
    .sppr_i               (sppr),
    .ss_i                 (ss),
    .sclk_o               (sclk),
    .BaudRateDivisor_o    (div),
    .miso_receive_sclk_o  (rcv),
    .miso_receive_sclk0_o (rcv0),
    .mosi_send_sclk_o     (snd),
    .mosi_send_sclk0_o    (snd0)
`ifdef SPI_BRG_FRAME_CNT_EN
    ,
    .frame_done_o         (frame_done)
`endif
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: n = PCLK edges since the frame went active, h = half period.
  // Toggle k (1-based) happens on edge k*h; odd k are leading edges.
  int m_n;
  int m_div;
  int m_spr;
  int m_sppr;
  bit m_sclk, m_rcv, m_rcv0, m_snd, m_snd0;

  always @(posedge PCLK or negedge PRESET_n) begin
    int  h;
    int  old_div;
    int  k;
    bit  en;
    bit  samp;
    if (!PRESET_n) begin
      m_n = 0; m_div = 2; m_spr = 0; m_sppr = 0;
      m_sclk = 1'b0; m_rcv = 1'b0; m_rcv0 = 1'b0; m_snd = 1'b0; m_snd0 = 1'b0;
    end else begin
      old_div = m_div;
      m_div = (m_sppr + 1) * (2 ** (m_spr + 1));
      en = !ss && (mode == 2'b00 || (mode == 2'b01 && !spiswai));
      if (!en) begin
        m_spr = int'(spr);
        m_sppr = int'(sppr);
        m_n = 0;
        m_sclk = cpol;
        m_rcv = 1'b0; m_rcv0 = 1'b0; m_snd = 1'b0; m_snd0 = 1'b0;
      end else begin
        m_n++;
        h = old_div / 2;
        if (h < 1) h = 1;
        m_sclk = cpol ^ ((m_n / h) % 2 == 1);
        m_rcv = 1'b0; m_snd = 1'b0; m_rcv0 = 1'b0; m_snd0 = 1'b0;
        if (m_n % h == 0) begin
          k = m_n / h;
          samp = (k % 2 == 1) ^ cpha;
          m_rcv = samp;
          m_snd = !samp;
        end
        if (m_n % h == (h - 1) % h) begin
          k = (m_n + h - 1) / h;
          samp = (k % 2 == 1) ^ cpha;
          m_rcv0 = samp;
          m_snd0 = !samp;
        end
      end
    end
  end

  // Compare every output away from the active edge
  always @(negedge PCLK) begin
    if (chk_en) begin
      check_val("sclk", 32'(sclk), 32'(m_sclk));
      check_val("rcv", 32'(rcv), 32'(m_rcv));
      check_val("rcv0", 32'(rcv0), 32'(m_rcv0));
      check_val("snd", 32'(snd), 32'(m_snd));
      check_val("snd0", 32'(snd0), 32'(m_snd0));
      check_val("div", 32'(div), 32'(m_div));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    int run_len;
    PRESET_n = 1'b0;
    cyc(3);
    check_val("rst_sclk", 32'(sclk), 32'd0);
    check_val("rst_strobes", 32'({rcv, rcv0, snd, snd0}), 32'd0);
    check_val("rst_div", 32'(div), 32'd2);
    PRESET_n = 1'b1;
    chk_en = 1'b1;

    // 1: divisor 8, mode 0
    spr = 3'd2; sppr = 3'd0; cpol = 1'b0; cpha = 1'b0; mode = 2'b00;
    cyc(3);
    check_val("t1_div", 32'(div), 32'd8);
    ss = 1'b0;
    cyc(40);
    // 2: cpol=1, cpha=1
    ss = 1'b1; cpol = 1'b1; cpha = 1'b1;
    cyc(3);
    check_val("t2_idle_sclk", 32'(sclk), 32'd1);
    ss = 1'b0;
    cyc(40);
    // 3: divisor 2
    ss = 1'b1; spr = 3'd0; cpol = 1'b0; cpha = 1'b0;
    cyc(3);
    check_val("t3_div", 32'(div), 32'd2);
    ss = 1'b0;
    cyc(20);
    // 4: rate change mid-frame is deferred to the next frame
    ss = 1'b1; spr = 3'd2;
    cyc(3);
    ss = 1'b0;
    cyc(10);
    spr = 3'd3;
    cyc(30);
    check_val("t4_div_frozen", 32'(div), 32'd8);
    ss = 1'b1;
    cyc(3);
    check_val("t4_div_new", 32'(div), 32'd16);
    ss = 1'b0;
    cyc(40);
    // 5: WAIT with spiswai stops SCLK, then resumes
    mode = 2'b01; spiswai = 1'b1;
    cyc(5);
    spiswai = 1'b0;
    cyc(30);
    mode = 2'b00;
    // 6: async reset mid-period
    cyc(3);
    #2;
    PRESET_n = 1'b0;
    #1;
    check_val("t6_sclk", 32'(sclk), 32'd0);
    check_val("t6_strobes", 32'({rcv, rcv0, snd, snd0}), 32'd0);
    check_val("t6_div", 32'(div), 32'd2);
    cyc(2);
    PRESET_n = 1'b1;
    ss = 1'b1;
    cyc(3);

    // Randomized frames with mid-frame rate writes and stop/wait interruptions
    for (int it = 0; it < 150; it++) begin
      ss = 1'b1;
      cpol = 1'($urandom_range(1, 0));
      cpha = 1'($urandom_range(1, 0));
      spr = 3'($urandom_range(3, 0));
      sppr = 3'($urandom_range(7, 0));
      mode = 2'b00;
      spiswai = 1'($urandom_range(1, 0));
      cyc(int'($urandom_range(5, 2)));
      ss = 1'b0;
      run_len = int'($urandom_range(150, 10));
      for (int c = 0; c < run_len; c++) begin
        if ($urandom_range(99, 0) < 3) begin
          spr = 3'($urandom_range(3, 0));
          sppr = 3'($urandom_range(7, 0));
        end
        if ($urandom_range(99, 0) < 2) begin
          mode = 2'($urandom_range(3, 1));
          spiswai = 1'b1;
          cyc(3);
          mode = 2'b00;
        end
        cyc(1);
      end
    end
    ss = 1'b1;
    cyc(3);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
